// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master: serialises din on mosi while shifting miso into dout.
// Configurable word width, SCLK divider, CPOL/CPHA and bit order.
module spi_master_duplex #(
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 4,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  new_data,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  done,
    output logic                  busy
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, TRANSFER, HOLD} state_t;

    state_t                state, state_next;
    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  tick;
    logic                  leading;
    logic                  last_edge;
    logic                  sample_edge;
    logic                  shift_edge;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                       input logic b);
        return LSB_FIRST ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    // edge_cnt holds edges already produced, so an even count means the next edge leads
    assign tick        = (div_cnt == DIV_LAST);
    assign leading     = ~edge_cnt[0];
    assign last_edge   = (edge_cnt == EDGE_LAST);
    assign sample_edge = CPHA ? ~leading : leading;
    assign shift_edge  = CPHA ? leading : (~leading && ~last_edge);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (new_data) state_next = TRANSFER;
            TRANSFER: if (tick && last_edge) state_next = HOLD;
            HOLD:     if (tick) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk     <= CPOL;
            cs       <= 1'b1;
            mosi     <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_data) begin
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        // CPHA=0 must present the first bit before the first edge
                        if (!CPHA) begin
                            mosi  <= first_bit(din);
                            tx_sr <= shift_out(din);
                        end else begin
                            tx_sr <= din;
                        end
                    end
                end
                TRANSFER: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) rx_sr <= shift_in(rx_sr, miso);
                        if (shift_edge) begin
                            mosi  <= first_bit(tx_sr);
                            tx_sr <= shift_out(tx_sr);
                        end
                    end
                end
                HOLD: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        cs   <= 1'b1;
                        mosi <= 1'b0;
                        busy <= 1'b0;
                        dout <= rx_sr;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
